// File: rtl/conv_tree_ser_ctrl.sv
// ---------------------------------------------------------------------------
// conv_tree_ser_ctrl
// Frame scheduler in front of the 8:1 serializer tree. Two requester channels
// share the tree through valid/ready handshakes. One 8-bit word is presented
// on PAR_OUT per frame of FRAME_LEN cycles. If nothing is granted, an idle
// fill word is driven instead. FRAME_START/DATA_VALID are also delayed by
// PIPE_LAT cycles (SER_FRAME/SER_VALID) so that downstream logic lines up
// with the serial stream.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   ENABLE              run request, sampled only at frame boundaries / IDLE
//   REQx_VALID/DATA     channel x word offer
//   REQx_READY          channel x word accepted this cycle (combinational)
//   PAR_OUT             word to the tree PAR_IN1..8 (bit0 -> PAR_IN1)
//   FRAME_START         1-cycle pulse with each new PAR_OUT value
//   DATA_VALID          PAR_OUT holds granted data for this frame
//   GRANT_ID            owner channel of the current frame
//   SER_FRAME/SER_VALID FRAME_START/DATA_VALID delayed PIPE_LAT cycles
//
// Build option: define CTS_PRIO_EN for fixed priority (channel 0 always wins
// on contention). Without it, contention is resolved round-robin.
// ---------------------------------------------------------------------------
module conv_tree_ser_ctrl #(
  parameter int          FRAME_LEN = 8,
  parameter int          PIPE_LAT  = 3,
  parameter logic [7:0]  IDLE_WORD = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_DATA,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_DATA,
  output logic       REQ1_READY,
  output logic [7:0] PAR_OUT,
  output logic       FRAME_START,
  output logic       DATA_VALID,
  output logic       GRANT_ID,
  output logic       SER_FRAME,
  output logic       SER_VALID
);

  localparam logic [7:0] CNT_MAX = 8'(FRAME_LEN - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] par_reg, par_next;
  logic       dv_reg, dv_next;
  logic       gid_reg, gid_next;
  logic       fs_reg, fs_next;

  logic       boundary;
  logic       load;
  logic       any_valid;
  logic       pick1;
  logic       grant;

  // A boundary is the last cycle of a running frame, or any enabled cycle
  // in IDLE (which also starts the first frame).
  assign boundary  = (state_reg == ST_IDLE) ? ENABLE : (cnt_reg == CNT_MAX);
  assign load      = boundary && ENABLE;
  assign any_valid = REQ0_VALID || REQ1_VALID;

`ifdef CTS_PRIO_EN
  // Fixed priority: channel 1 only wins when channel 0 is not offering.
  assign pick1 = REQ1_VALID && !REQ0_VALID;
`else
  // LAST = channel granted most recently; on contention the other one wins.
  logic last_reg, last_next;

  assign pick1 = REQ1_VALID && (!REQ0_VALID || !last_reg);

  always_comb begin
    last_next = last_reg;
    if (grant) begin
      last_next = pick1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end
`endif

  assign grant      = load && any_valid && !RESET;
  assign REQ0_READY = grant && !pick1;
  assign REQ1_READY = grant && pick1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    dv_next    = dv_reg;
    gid_next   = gid_reg;
    fs_next    = 1'b0;
    if (load) begin
      state_next = ST_RUN;
      cnt_next   = 8'd0;
      fs_next    = 1'b1;
      par_next   = any_valid ? (pick1 ? REQ1_DATA : REQ0_DATA) : IDLE_WORD;
      dv_next    = any_valid;
      gid_next   = any_valid && pick1;
    end else if (state_reg == ST_RUN) begin
      if (boundary) begin
        // ENABLE low at the end of a frame: drop back to idle fill.
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
        par_next   = IDLE_WORD;
        dv_next    = 1'b0;
        gid_next   = 1'b0;
      end else begin
        cnt_next = cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      par_reg   <= IDLE_WORD;
      dv_reg    <= 1'b0;
      gid_reg   <= 1'b0;
      fs_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
      dv_reg    <= dv_next;
      gid_reg   <= gid_next;
      fs_reg    <= fs_next;
    end
  end

  // Delay lines aligning the frame markers with the tree output.
  // Stage 0 is the undelayed marker; stage PIPE_LAT is the output.
  logic [PIPE_LAT:0] fs_line;
  logic [PIPE_LAT:0] dv_line;

  assign fs_line[0] = fs_reg;
  assign dv_line[0] = dv_reg;

  generate
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_dly
      always_ff @(posedge CLK) begin
        if (RESET) begin
          fs_line[gi+1] <= 1'b0;
          dv_line[gi+1] <= 1'b0;
        end else begin
          fs_line[gi+1] <= fs_line[gi];
          dv_line[gi+1] <= dv_line[gi];
        end
      end
    end
  endgenerate

  assign PAR_OUT     = par_reg;
  assign FRAME_START = fs_reg;
  assign DATA_VALID  = dv_reg;
  assign GRANT_ID    = gid_reg;
  assign SER_FRAME   = fs_line[PIPE_LAT];
  assign SER_VALID   = dv_line[PIPE_LAT];

endmodule
